serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer. It drives a single 1-bit full-adder cell over WIDTH cycles, LSB first, and keeps the carry in a flip-flop between bits. A start/busy/done handshake lets a host issue multi-bit additions while the design holds only one full-adder cell. It sits between the host logic and the full-adder datapath.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_adder_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and a
// constant-width helper for sizing the bit counter.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single 1-bit full adder cell; the only arithmetic in the serial adder.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds one full-adder cell LSB first over WIDTH
// cycles. Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int          CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             accept, last_bit;

    serial_fa_cell u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // start only counts outside RUN; a request mid-operation is dropped.
    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (state == ST_RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            sum   <= {fa_s, sum[WIDTH-1:1]};
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB on the final bit.
                ovf  <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): expected results are
// queued at stimulus time and popped whenever done pulses.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int           n_vec = 0;
    int           n_err = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_e;
    int           lat, bcnt;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // {ovf, cout, sum}; ovf from the sign rule, independent of carries.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_done_excl", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", {56'd0, sum}, {56'd0, mon_e[W-1:0]});
                chk("cout", {63'd0, cout}, {63'd0, mon_e[W]});
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", {63'd0, ovf}, {63'd0, mon_e[W+1]});
`endif
            end
        end
    end

    // Called one cycle into RUN (lat0 = cycles since accept); bounded wait for done.
    task automatic wait_done(input int lat0, output int l, output int bc);
        l  = lat0;
        bc = 0;
        while (!done && l < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input string tag);
        int l, bc;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; start = 1'b1;
        exp_q.push_back(model(x, y, ci));
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        wait_done(1, l, bc);
        chk({tag, "_latency"}, 64'(l), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(W));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {56'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;

        run_add(8'h5A, 8'h3C, 1'b0, "t1");
        run_add(8'hFF, 8'h01, 1'b0, "t2a");
        run_add(8'hFF, 8'h00, 1'b1, "t2b");

        // start pulse in the third RUN cycle must be ignored
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4, lat, bcnt);
        chk("t3_latency", 64'(lat), 64'(W + 1));
        @(posedge clk); #1;
        chk("t3_idle_after", {63'd0, busy}, 64'd0);

        // reset while bit 4 is being computed
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_done", {63'd0, done}, 64'd0);
        chk("t4_sum", {56'd0, sum}, 64'd0);
        chk("t4_cout", {63'd0, cout}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("t4_ovf", {63'd0, ovf}, 64'd0);
`endif
        rst = 1'b0;
        run_add(8'h01, 8'h01, 1'b0, "t4_fresh");

        // start held high: back-to-back operations with no idle cycle
        @(posedge clk); #1;
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h03, 8'h04, 1'b0));
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80;
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        wait_done(1, lat, bcnt);
        chk("t5a_latency", 64'(lat), 64'(W + 1));
        chk("t5a_busy_cycles", 64'(bcnt), 64'(W));
        @(posedge clk); #1;
        chk("t5_no_idle", {63'd0, busy}, 64'd1);
        a = 8'h11; b = 8'h22;
        wait_done(1, lat, bcnt);
        chk("t5b_period", 64'(lat), 64'(W + 1));
        chk("t5b_busy_cycles", 64'(bcnt), 64'(W));
        start = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle_after", {63'd0, busy}, 64'd0);

`ifdef SERIAL_ADDER_OVF_EN
        run_add(8'h7F, 8'h01, 1'b0, "t6a");
        run_add(8'hFF, 8'h01, 1'b0, "t6b");
`endif

        for (int i = 0; i < 6; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), "rnd");
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
